// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings used by the ROM arbiter and its request capture stages.
package ahbl_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY = 1'b0;

   localparam int NPORTS = 2;

   // IDLE and BUSY carry no address phase and must never reach the ROM.
   function automatic logic htrans_active(input logic [1:0] htrans);
      return !((htrans == HTRANS_IDLE) || (htrans == HTRANS_BUSY));
   endfunction

endpackage

// File: rtl/ahbl_req_capture.sv
// Per-port address-phase capture: holds a request that could not be issued
// and presents either it or the live address phase to the arbiter core.
module ahbl_req_capture
   import ahbl_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hsel,
   input  logic [1:0]    htrans,
   input  logic          hready,
   input  logic [AW-1:0] haddr,
   input  logic          grant,
   output logic          req,
   output logic [AW-1:0] addr,
   output logic          pend
);

   logic          live;
   logic          pend_v;
   logic [AW-1:0] pend_addr;

   assign live = hsel & htrans_active(htrans) & hready;

   // A port whose request is pending has HREADY low, so live and pend_v
   // are never both set; a grant therefore always consumes the one request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v    <= 1'b0;
         pend_addr <= '0;
      end else if (grant) begin
         pend_v    <= 1'b0;
      end else if (live) begin
         pend_v    <= 1'b1;
         pend_addr <= haddr;
      end
   end

   assign req  = live | pend_v;
   assign addr = pend_v ? pend_addr : haddr;
   assign pend = pend_v;

endmodule

// File: rtl/ahbl_rom_arbiter.sv
// Two-master AHB-Lite read arbiter in front of a single-ported ROM: port 0 is
// the instruction bus, port 1 the accelerator/DMA bus.
module ahbl_rom_arbiter
   import ahbl_pkg::*;
#(
   parameter int ROUND_ROBIN = 1,
   parameter int AW          = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,

   input  logic          S0_HSEL,
   input  logic [AW-1:0] S0_HADDR,
   input  logic [1:0]    S0_HTRANS,
   input  logic          S0_HWRITE,
   input  logic          S0_HREADY,
   output logic          S0_HREADYOUT,
   output logic [31:0]   S0_HRDATA,
   output logic          S0_HRESP,

   input  logic          S1_HSEL,
   input  logic [AW-1:0] S1_HADDR,
   input  logic [1:0]    S1_HTRANS,
   input  logic          S1_HWRITE,
   input  logic          S1_HREADY,
   output logic          S1_HREADYOUT,
   output logic [31:0]   S1_HRDATA,
   output logic          S1_HRESP,

   output logic          M_HSEL,
   output logic [AW-1:0] M_HADDR,
   output logic          M_HREADY,
   input  logic          M_HREADYOUT,
   input  logic [31:0]   M_HRDATA
);

   logic [NPORTS-1:0] sel;
   logic [NPORTS-1:0] ready_in;
   logic [1:0]        trans    [NPORTS];
   logic [AW-1:0]     addr_in  [NPORTS];
   logic [AW-1:0]     addr_eff [NPORTS];
   logic [NPORTS-1:0] req;
   logic [NPORTS-1:0] pend;
   logic [NPORTS-1:0] grant;
   logic [NPORTS-1:0] readyout;
   logic [31:0]       rdata    [NPORTS];

   logic dp_v;
   logic dp_owner;
   logic last_grant;

   // ROM has no write path: write data phases complete as OKAY reads.
   logic unused_hwrite;
   assign unused_hwrite = S0_HWRITE ^ S1_HWRITE;

   assign sel        = {S1_HSEL, S0_HSEL};
   assign ready_in   = {S1_HREADY, S0_HREADY};
   assign trans[0]   = S0_HTRANS;
   assign trans[1]   = S1_HTRANS;
   assign addr_in[0] = S0_HADDR;
   assign addr_in[1] = S1_HADDR;

   generate
      for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
         ahbl_req_capture #(
            .AW (AW)
         ) u_capture (
            .clk    (HCLK),
            .rst_n  (HRESETn),
            .hsel   (sel[gi]),
            .htrans (trans[gi]),
            .hready (ready_in[gi]),
            .haddr  (addr_in[gi]),
            .grant  (grant[gi]),
            .req    (req[gi]),
            .addr   (addr_eff[gi]),
            .pend   (pend[gi])
         );

         assign readyout[gi] = !pend[gi] &&
                               !(dp_v && (dp_owner == 1'(gi)) && !M_HREADYOUT);
         assign rdata[gi]    = (dp_v && (dp_owner == 1'(gi))) ? M_HRDATA : 32'h0;
      end
   endgenerate

   // Issue only when the ROM slot is free; reset also blocks issue so the
   // ROM sees an idle bus while HRESETn is low.
   always_comb begin
      grant = '0;
      if (HRESETn && M_HREADYOUT) begin
         if (req[0] && req[1]) begin
            if (ROUND_ROBIN != 0) begin
               grant = last_grant ? 2'b01 : 2'b10;
            end else begin
               grant = 2'b01;
            end
         end else begin
            grant = req;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_v       <= 1'b0;
         dp_owner   <= 1'b0;
         last_grant <= 1'b1;
      end else if (M_HREADYOUT) begin
         dp_v <= |grant;
         if (|grant) begin
            dp_owner   <= grant[1];
            last_grant <= grant[1];
         end
      end
   end

   assign M_HSEL   = |grant;
   assign M_HADDR  = grant[1] ? addr_eff[1] :
                     grant[0] ? addr_eff[0] : '0;
   assign M_HREADY = M_HREADYOUT;

   assign S0_HREADYOUT = readyout[0];
   assign S1_HREADYOUT = readyout[1];
   assign S0_HRDATA    = rdata[0];
   assign S1_HRDATA    = rdata[1];
   assign S0_HRESP     = HRESP_OKAY;
   assign S1_HRESP     = HRESP_OKAY;

endmodule

// File: tb/tb_ahbl_rom_arbiter.sv
// Directed bench for ahbl_rom_arbiter: a round-robin and a fixed-priority
// instance share master stimulus; each has its own zero-wait ROM model.
module tb_ahbl_rom_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic        clk = 1'b0;
   logic        hresetn;
   logic        s0_hsel, s0_hwrite, s1_hsel, s1_hwrite;
   logic [1:0]  s0_htrans, s1_htrans;
   logic [31:0] s0_haddr, s1_haddr;
   logic        m_hreadyout;

   logic        rr_s0_rdy, rr_s1_rdy, rr_s0_resp, rr_s1_resp, rr_m_hsel, rr_m_hready;
   logic [31:0] rr_s0_rdata, rr_s1_rdata, rr_m_haddr, rr_rom;
   logic        fp_s0_rdy, fp_s1_rdy, fp_s0_resp, fp_s1_resp, fp_m_hsel, fp_m_hready;
   logic [31:0] fp_s0_rdata, fp_s1_rdata, fp_m_haddr, fp_rom;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ahbl_rom_arbiter #(.ROUND_ROBIN(1), .AW(32)) dut_rr (
      .HCLK(clk), .HRESETn(hresetn),
      .S0_HSEL(s0_hsel), .S0_HADDR(s0_haddr), .S0_HTRANS(s0_htrans), .S0_HWRITE(s0_hwrite),
      .S0_HREADY(rr_s0_rdy), .S0_HREADYOUT(rr_s0_rdy), .S0_HRDATA(rr_s0_rdata), .S0_HRESP(rr_s0_resp),
      .S1_HSEL(s1_hsel), .S1_HADDR(s1_haddr), .S1_HTRANS(s1_htrans), .S1_HWRITE(s1_hwrite),
      .S1_HREADY(rr_s1_rdy), .S1_HREADYOUT(rr_s1_rdy), .S1_HRDATA(rr_s1_rdata), .S1_HRESP(rr_s1_resp),
      .M_HSEL(rr_m_hsel), .M_HADDR(rr_m_haddr), .M_HREADY(rr_m_hready),
      .M_HREADYOUT(m_hreadyout), .M_HRDATA(rr_rom)
   );

   ahbl_rom_arbiter #(.ROUND_ROBIN(0), .AW(32)) dut_fp (
      .HCLK(clk), .HRESETn(hresetn),
      .S0_HSEL(s0_hsel), .S0_HADDR(s0_haddr), .S0_HTRANS(s0_htrans), .S0_HWRITE(s0_hwrite),
      .S0_HREADY(fp_s0_rdy), .S0_HREADYOUT(fp_s0_rdy), .S0_HRDATA(fp_s0_rdata), .S0_HRESP(fp_s0_resp),
      .S1_HSEL(s1_hsel), .S1_HADDR(s1_haddr), .S1_HTRANS(s1_htrans), .S1_HWRITE(s1_hwrite),
      .S1_HREADY(fp_s1_rdy), .S1_HREADYOUT(fp_s1_rdy), .S1_HRDATA(fp_s1_rdata), .S1_HRESP(fp_s1_resp),
      .M_HSEL(fp_m_hsel), .M_HADDR(fp_m_haddr), .M_HREADY(fp_m_hready),
      .M_HREADYOUT(m_hreadyout), .M_HRDATA(fp_rom)
   );

   // ROM contents: word at address a is {16'hC0DE, a[15:0]}.
   always @(posedge clk) begin
      if (rr_m_hsel && rr_m_hready) rr_rom <= {16'hC0DE, rr_m_haddr[15:0]};
      if (fp_m_hsel && fp_m_hready) fp_rom <= {16'hC0DE, fp_m_haddr[15:0]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic p0(input logic s, input logic [1:0] t, input logic [31:0] a);
      s0_hsel = s; s0_htrans = t; s0_haddr = a;
   endtask

   task automatic p1(input logic s, input logic [1:0] t, input logic [31:0] a);
      s1_hsel = s; s1_htrans = t; s1_haddr = a;
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      tick();
      hresetn = 1'b1;
   endtask

   initial begin
      hresetn = 1'b0; m_hreadyout = 1'b1;
      s0_hwrite = 1'b0; s1_hwrite = 1'b0;
      p0(0, IDLE, 32'h0); p1(0, IDLE, 32'h0);
      #12;
      chk("rst_s0_rdy", rr_s0_rdy, 1);
      chk("rst_s1_rdy", rr_s1_rdy, 1);
      chk("rst_s0_rdata", rr_s0_rdata, 0);
      chk("rst_s1_rdata", rr_s1_rdata, 0);
      chk("rst_resp", {rr_s0_resp, rr_s1_resp, fp_s0_resp, fp_s1_resp}, 0);
      chk("rst_m_hsel", rr_m_hsel, 0);
      chk("rst_m_haddr", rr_m_haddr, 0);
      tick();
      hresetn = 1'b1;

      // Port 0 alone: NONSEQ 0x100, SEQ 0x104
      p0(1, NONSEQ, 32'h100); settle();
      chk("t1_hsel", rr_m_hsel, 1);
      chk("t1_addr0", rr_m_haddr, 32'h100);
      chk("t1_rdy0", rr_s0_rdy, 1);
      tick();
      p0(1, SEQ, 32'h104); settle();
      chk("t1_addr1", rr_m_haddr, 32'h104);
      chk("t1_data0", rr_s0_rdata, 32'hC0DE0100);
      chk("t1_rdy1", rr_s0_rdy, 1);
      tick();
      p0(0, IDLE, 32'h0); settle();
      chk("t1_data1", rr_s0_rdata, 32'hC0DE0104);
      chk("t1_rdy2", rr_s0_rdy, 1);
      chk("t1_idle", rr_m_hsel, 0);
      tick();

      // Conflict right after reset: port 0 first, port 1 one wait state
      do_reset();
      p0(1, NONSEQ, 32'h200); p1(1, NONSEQ, 32'h300); settle();
      chk("t2_addr0", rr_m_haddr, 32'h200);
      chk("t2_rdy1a", rr_s1_rdy, 1);
      tick();
      p0(0, IDLE, 32'h0); settle();
      chk("t2_data0", rr_s0_rdata, 32'hC0DE0200);
      chk("t2_rdy1b", rr_s1_rdy, 0);
      chk("t2_addr1", rr_m_haddr, 32'h300);
      tick();
      p1(0, IDLE, 32'h0); settle();
      chk("t2_data1", rr_s1_rdata, 32'hC0DE0300);
      chk("t2_rdy1c", rr_s1_rdy, 1);
      chk("t2_data0z", rr_s0_rdata, 0);
      chk("t2_idle", rr_m_hsel, 0);
      tick();

      // Round-robin streaming: grants alternate 0,1,0,1,0
      p0(1, NONSEQ, 32'h400); p1(1, NONSEQ, 32'h500); settle();
      chk("rr_g0", rr_m_haddr, 32'h400);
      tick();
      p0(1, SEQ, 32'h404); settle();
      chk("rr_d0", rr_s0_rdata, 32'hC0DE0400);
      chk("rr_rdy0a", rr_s0_rdy, 1);
      chk("rr_rdy1a", rr_s1_rdy, 0);
      chk("rr_g1", rr_m_haddr, 32'h500);
      tick();
      p1(1, SEQ, 32'h504); settle();
      chk("rr_d1", rr_s1_rdata, 32'hC0DE0500);
      chk("rr_rdy1b", rr_s1_rdy, 1);
      chk("rr_rdy0b", rr_s0_rdy, 0);
      chk("rr_g2", rr_m_haddr, 32'h404);
      tick();
      p0(1, SEQ, 32'h408); settle();
      chk("rr_d2", rr_s0_rdata, 32'hC0DE0404);
      chk("rr_rdy1c", rr_s1_rdy, 0);
      chk("rr_g3", rr_m_haddr, 32'h504);
      tick();
      p1(0, IDLE, 32'h0); settle();
      chk("rr_d3", rr_s1_rdata, 32'hC0DE0504);
      chk("rr_rdy0c", rr_s0_rdy, 0);
      chk("rr_g4", rr_m_haddr, 32'h408);
      tick();
      p0(0, IDLE, 32'h0); settle();
      chk("rr_d4", rr_s0_rdata, 32'hC0DE0408);
      chk("rr_rdy0d", rr_s0_rdy, 1);
      chk("rr_idle", rr_m_hsel, 0);
      tick();

      // Fixed priority: port 1 waits until port 0 stops requesting
      do_reset();
      p0(1, NONSEQ, 32'h600); p1(1, NONSEQ, 32'h700); settle();
      chk("fp_g0", fp_m_haddr, 32'h600);
      tick();
      p0(1, SEQ, 32'h604); settle();
      chk("fp_g1", fp_m_haddr, 32'h604);
      chk("fp_rdy1a", fp_s1_rdy, 0);
      chk("fp_d0", fp_s0_rdata, 32'hC0DE0600);
      tick();
      p0(1, SEQ, 32'h608); settle();
      chk("fp_g2", fp_m_haddr, 32'h608);
      chk("fp_rdy1b", fp_s1_rdy, 0);
      chk("fp_rdy0", fp_s0_rdy, 1);
      tick();
      p0(0, IDLE, 32'h0); settle();
      chk("fp_g3", fp_m_haddr, 32'h700);
      chk("fp_d2", fp_s0_rdata, 32'hC0DE0608);
      tick();
      p1(0, IDLE, 32'h0); settle();
      chk("fp_d3", fp_s1_rdata, 32'hC0DE0700);
      chk("fp_rdy1c", fp_s1_rdy, 1);
      chk("fp_idle", fp_m_hsel, 0);
      tick();

      // IDLE and BUSY with HSEL=1 are not requests
      do_reset();
      p1(1, IDLE, 32'h20); settle();
      chk("idle_hsel", rr_m_hsel, 0);
      chk("idle_rdy1", rr_s1_rdy, 1);
      tick();
      p1(1, BUSY, 32'h24); settle();
      chk("busy_hsel", rr_m_hsel, 0);
      chk("busy_addr", rr_m_haddr, 0);
      chk("busy_rdy1", rr_s1_rdy, 1);
      tick();
      p1(0, IDLE, 32'h0); settle();
      chk("busy_rdata", rr_s1_rdata, 0);
      tick();

      // Write to 0x10 completes OKAY; following read returns ROM word
      s1_hwrite = 1'b1; p1(1, NONSEQ, 32'h10); settle();
      chk("wr_hsel", rr_m_hsel, 1);
      chk("wr_addr", rr_m_haddr, 32'h10);
      tick();
      s1_hwrite = 1'b0; p1(1, NONSEQ, 32'h10); settle();
      chk("wr_resp", rr_s1_resp, 0);
      chk("wr_rdy", rr_s1_rdy, 1);
      chk("rd_addr", rr_m_haddr, 32'h10);
      tick();
      p1(0, IDLE, 32'h0); settle();
      chk("rd_data", rr_s1_rdata, 32'hC0DE0010);
      tick();

      // ROM stall: owner waits, new live request is captured
      p0(1, NONSEQ, 32'hA00); settle();
      chk("st_addr0", rr_m_haddr, 32'hA00);
      tick();
      m_hreadyout = 1'b0; p0(0, IDLE, 32'h0); p1(1, NONSEQ, 32'hB00); settle();
      chk("st_rdy0", rr_s0_rdy, 0);
      chk("st_hsel", rr_m_hsel, 0);
      chk("st_rdy1", rr_s1_rdy, 1);
      tick();
      m_hreadyout = 1'b1; settle();
      chk("st_rdy0b", rr_s0_rdy, 1);
      chk("st_data0", rr_s0_rdata, 32'hC0DE0A00);
      chk("st_rdy1b", rr_s1_rdy, 0);
      chk("st_addr1", rr_m_haddr, 32'hB00);
      tick();
      p1(0, IDLE, 32'h0); settle();
      chk("st_data1", rr_s1_rdata, 32'hC0DE0B00);
      chk("st_rdy1c", rr_s1_rdy, 1);
      tick();

      // Reset while port 1 is pending
      p0(1, NONSEQ, 32'h800); p1(1, NONSEQ, 32'h900); settle();
      chk("ar_addr0", rr_m_haddr, 32'h800);
      tick();
      p0(0, IDLE, 32'h0);
      #1;
      chk("ar_pend", rr_s1_rdy, 0);
      hresetn = 1'b0;
      #1;
      chk("ar_rdy1", rr_s1_rdy, 1);
      chk("ar_rdy0", rr_s0_rdy, 1);
      chk("ar_hsel", rr_m_hsel, 0);
      chk("ar_haddr", rr_m_haddr, 0);
      chk("ar_rdata0", rr_s0_rdata, 0);
      p1(0, IDLE, 32'h0);
      tick();
      hresetn = 1'b1; settle();
      chk("ar_post0", rr_m_hsel, 0);
      tick();
      settle();
      chk("ar_post1", rr_m_hsel, 0);
      chk("ar_post_rdy1", rr_s1_rdy, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
